regs_seq: RTL

Register-transfer sequencer for the 8080 core's 16 x 16-bit register file. It accepts one register micro-op at a time over a valid/ready command interface and drives the register file's two read ports and one write port. It absorbs the file's one-cycle registered-address read latency and performs the small ALU work the register pairs need: move, increment/decrement, 16-bit add with carry, exchange, and load-immediate. It sits between the instruction decoder and the register file.

---
 rtl/regs_seq_if.sv | 30 +++
 rtl/regs_seq.sv | 132 +++++++++++++
 2 files changed

// File: rtl/regs_seq_if.sv
// Command and register-file bus between the 8080 decoder/register file and regs_seq.
// master = decoder plus register file side, slave = the sequencer.
interface regs_seq_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [3:0]  cmd_ra;
    logic [3:0]  cmd_rb;
    logic [3:0]  cmd_rd;
    logic [15:0] cmd_imm;
    logic        done;
    logic        carry;
    logic [3:0]  raddr0_;
    logic [3:0]  raddr1_;
    logic [15:0] rdata0;
    logic [15:0] rdata1;
    logic        wen;
    logic [3:0]  waddr;
    logic [15:0] wdata;

    modport master (
        output cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_rd, cmd_imm, rdata0, rdata1,
        input  cmd_ready, done, carry, raddr0_, raddr1_, wen, waddr, wdata
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_rd, cmd_imm, rdata0, rdata1,
        output cmd_ready, done, carry, raddr0_, raddr1_, wen, waddr, wdata
    );
endinterface

// File: rtl/regs_seq.sv
// Register-transfer sequencer: one micro-op at a time against a 16x16 register file
// whose read data lags its registered read address by one cycle.
module regs_seq (
    input  logic       clk,
    input  logic       reset,
    regs_seq_if.slave  bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RADDR  = 2'd1;
    localparam logic [1:0] S_EXEC   = 2'd2;
    localparam logic [1:0] S_WRITE2 = 2'd3;

    localparam logic [2:0] OP_MOV  = 3'd1;
    localparam logic [2:0] OP_INX  = 3'd2;
    localparam logic [2:0] OP_DCX  = 3'd3;
    localparam logic [2:0] OP_DAD  = 3'd4;
    localparam logic [2:0] OP_XCHG = 3'd5;
    localparam logic [2:0] OP_LDI  = 3'd6;

    logic [1:0]  state_q, state_d;
    logic [2:0]  op_q;
    logic [3:0]  ra_q, rb_q, rd_q;
    logic [15:0] imm_q;
    logic [15:0] tmp_q, tmp_d;
    logic [3:0]  raddr0_q, raddr1_q;
    logic        carry_q, carry_d;

    logic        accept;
    logic [16:0] sum;
    logic        wen_c, done_c;
    logic [3:0]  waddr_c;
    logic [15:0] wdata_c;

    assign bus.cmd_ready = (state_q == S_IDLE) && !reset;
    assign accept        = bus.cmd_valid && bus.cmd_ready;
    assign sum           = {1'b0, bus.rdata0} + {1'b0, bus.rdata1};

    always_comb begin
        state_d = state_q;
        tmp_d   = tmp_q;
        carry_d = carry_q;
        wen_c   = 1'b0;
        done_c  = 1'b0;
        waddr_c = rd_q;
        wdata_c = bus.rdata0;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_RADDR;
            S_RADDR: state_d = S_EXEC;
            S_EXEC: begin
                case (op_q)
                    OP_MOV: wen_c = 1'b1;
                    OP_INX: begin
                        wen_c   = 1'b1;
                        wdata_c = bus.rdata0 + 16'd1;
                    end
                    OP_DCX: begin
                        wen_c   = 1'b1;
                        wdata_c = bus.rdata0 - 16'd1;
                    end
                    OP_DAD: begin
                        wen_c   = 1'b1;
                        wdata_c = sum[15:0];
                        carry_d = sum[16];
                    end
                    OP_LDI: begin
                        wen_c   = 1'b1;
                        wdata_c = imm_q;
                    end
                    OP_XCHG: begin
                        // A is parked in tmp so the second write can complete the swap
                        wen_c   = 1'b1;
                        waddr_c = ra_q;
                        wdata_c = bus.rdata1;
                        tmp_d   = bus.rdata0;
                    end
                    default: ;
                endcase
                if (op_q == OP_XCHG) begin
                    state_d = S_WRITE2;
                end else begin
                    done_c  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_WRITE2: begin
                wen_c   = 1'b1;
                waddr_c = rb_q;
                wdata_c = tmp_q;
                done_c  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= 3'd0;
            ra_q     <= 4'd0;
            rb_q     <= 4'd0;
            rd_q     <= 4'd0;
            imm_q    <= 16'd0;
            tmp_q    <= 16'd0;
            raddr0_q <= 4'd0;
            raddr1_q <= 4'd0;
            carry_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tmp_q   <= tmp_d;
            carry_q <= carry_d;
            if (accept) begin
                op_q     <= bus.cmd_op;
                ra_q     <= bus.cmd_ra;
                rb_q     <= bus.cmd_rb;
                rd_q     <= bus.cmd_rd;
                imm_q    <= bus.cmd_imm;
                raddr0_q <= bus.cmd_ra;
                raddr1_q <= bus.cmd_rb;
            end
        end
    end

    // Writes and completion are suppressed whenever reset is high, even mid-op
    assign bus.wen     = wen_c && !reset;
    assign bus.done    = done_c && !reset;
    assign bus.waddr   = waddr_c;
    assign bus.wdata   = wdata_c;
    assign bus.carry   = carry_q;
    assign bus.raddr0_ = raddr0_q;
    assign bus.raddr1_ = raddr1_q;
endmodule
